// File: rtl/alsu_result_checker_if.sv
// -----------------------------------------------------------------------------
// alsu_result_checker_if
// Stream bundle between a reference source / ALSU and the result checker.
//   exp_valid / exp_data / exp_ready : expected-value push channel
//   act_valid / act_data             : ALSU result stream (no back-pressure)
// Modports:
//   master : drives the streams (golden model, sequencer, testbench)
//   slave  : the checker; returns exp_ready
// -----------------------------------------------------------------------------
interface alsu_result_checker_if #(
  parameter int WIDTH = 6
);
  logic             exp_valid;
  logic [WIDTH-1:0] exp_data;
  logic             exp_ready;
  logic             act_valid;
  logic [WIDTH-1:0] act_data;

  modport master (
    output exp_valid, exp_data, act_valid, act_data,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_data, act_valid, act_data,
    output exp_ready
  );
endinterface

// File: rtl/alsu_result_checker.sv
// -----------------------------------------------------------------------------
// alsu_result_checker
// Compares a stream of ALSU results against expected values buffered in a
// small FIFO, counts matches / mismatches and captures the first mismatch.
// A run covers num_checks comparisons and is framed by start / done.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   start           : one-cycle pulse, begins a run from IDLE or DONE
//   num_checks      : comparisons in the run, sampled on the accepted start
//   bus (slave)     : expected-value push channel and actual-result stream
//   busy, done      : FSM in RUN / DONE
//   correct_count   : saturating count of matching comparisons
//   error_count     : saturating count of mismatching comparisons
//   err_flag        : sticky, a mismatch occurred this run
//   underflow       : sticky, a result arrived while the FIFO was empty
//   first_err_*     : index, expected and actual value of the first mismatch
// -----------------------------------------------------------------------------
module alsu_result_checker #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_checks,
  alsu_result_checker_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     correct_count,
  output logic [CNT_W-1:0]     error_count,
  output logic                 err_flag,
  output logic                 underflow,
  output logic [CNT_W-1:0]     first_err_idx,
  output logic [WIDTH-1:0]     first_err_exp,
  output logic [WIDTH-1:0]     first_err_act
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  state_t             state_r, state_nxt_s;
  logic [WIDTH-1:0]   mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]      count_r, count_nxt_s;
  logic               exp_ready_r, busy_r, done_r;
  logic [CNT_W-1:0]   num_checks_r, chk_idx_r, chk_idx_inc_s;
  logic [CNT_W-1:0]   correct_r, error_r, first_idx_r;
  logic               err_flag_r, underflow_r;
  logic [WIDTH-1:0]   first_exp_r, first_act_r, head_s;
  logic               in_run_s, push_s, pop_s, underflow_s, clear_s, last_s;

  // Handshake qualifiers; exp_ready_r already folds in RUN and not-full.
  assign in_run_s      = (state_r == ST_RUN);
  assign push_s        = in_run_s && bus.exp_valid && exp_ready_r;
  assign pop_s         = in_run_s && bus.act_valid && (count_r != CW'(0));
  assign underflow_s   = in_run_s && bus.act_valid && (count_r == CW'(0));
  assign head_s        = mem_r[rd_ptr_r];
  assign chk_idx_inc_s = chk_idx_r + CNT_W'(1);
  assign last_s        = (chk_idx_inc_s == num_checks_r);

  // Next-state decode and run-clear request.
  always_comb begin
    state_nxt_s = state_r;
    clear_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear_s     = 1'b1;
          state_nxt_s = (num_checks == {CNT_W{1'b0}}) ? ST_DONE : ST_RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (pop_s && last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (clear_s) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Expected-value FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clear_s) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.exp_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Registered status outputs, computed from next state so they line up
  // with the state register; ready stays low for the cycle after a full FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      exp_ready_r <= 1'b0;
    end else begin
      busy_r      <= (state_nxt_s == ST_RUN);
      done_r      <= (state_nxt_s == ST_DONE);
      exp_ready_r <= (state_nxt_s == ST_RUN) && (count_nxt_s != FULL_CNT);
    end
  end

  // Compare results: counters, sticky flags and first-mismatch capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_checks_r <= {CNT_W{1'b0}};
      chk_idx_r    <= {CNT_W{1'b0}};
      correct_r    <= {CNT_W{1'b0}};
      error_r      <= {CNT_W{1'b0}};
      err_flag_r   <= 1'b0;
      underflow_r  <= 1'b0;
      first_idx_r  <= {CNT_W{1'b0}};
      first_exp_r  <= {WIDTH{1'b0}};
      first_act_r  <= {WIDTH{1'b0}};
    end else if (clear_s) begin
      num_checks_r <= num_checks;
      chk_idx_r    <= {CNT_W{1'b0}};
      correct_r    <= {CNT_W{1'b0}};
      error_r      <= {CNT_W{1'b0}};
      err_flag_r   <= 1'b0;
      underflow_r  <= 1'b0;
      first_idx_r  <= {CNT_W{1'b0}};
      first_exp_r  <= {WIDTH{1'b0}};
      first_act_r  <= {WIDTH{1'b0}};
    end else begin
      if (pop_s) begin
        chk_idx_r <= chk_idx_inc_s;
        if (head_s == bus.act_data) begin
          correct_r <= sat_inc(correct_r);
        end else begin
          error_r    <= sat_inc(error_r);
          err_flag_r <= 1'b1;
          if (!err_flag_r) begin
            first_idx_r <= chk_idx_r;
            first_exp_r <= head_s;
            first_act_r <= bus.act_data;
          end
        end
      end
      if (underflow_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign bus.exp_ready  = exp_ready_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign correct_count  = correct_r;
  assign error_count    = error_r;
  assign err_flag       = err_flag_r;
  assign underflow      = underflow_r;
  assign first_err_idx  = first_idx_r;
  assign first_err_exp  = first_exp_r;
  assign first_err_act  = first_act_r;

endmodule

// File: doc/alsu_result_checker.md
Name: alsu_result_checker

Overview:
- Hardware response-side checker for the ALSU. It consumes the stream of ALSU results and compares each one against expected values pushed in by a reference source, such as the golden model or a command sequencer.
- Buffers expected values in a small FIFO so both streams can be offset by up to DEPTH cycles.
- Counts correct and erroneous results and captures the first mismatch.
- Run length is bounded: a programmed number of checks, with a start/done handshake.

Parameters:
- WIDTH, 6: result width; matches the ALSU out port (signed 6-bit).
- DEPTH, 4: expected-value FIFO depth; power of two, at least 2.
- CNT_W, 16: width of the check, correct and error counters and of num_checks.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse; begins a run
- num_checks  in  CNT_W  number of comparisons in the run; sampled on the accepted start
- exp_valid  in  1  expected value present
- exp_data  in  WIDTH  expected ALSU result
- exp_ready  out  1  FIFO can accept exp_data
- act_valid  in  1  ALSU result present this cycle
- act_data  in  WIDTH  ALSU out
- busy  out  1  FSM in RUN
- done  out  1  FSM in DONE
- correct_count  out  CNT_W  matching comparisons
- error_count  out  CNT_W  mismatching comparisons
- err_flag  out  1  sticky; at least one mismatch this run
- underflow  out  1  sticky; act_valid arrived with FIFO empty
- first_err_idx  out  CNT_W  check index (0-based) of the first mismatch
- first_err_exp  out  WIDTH  expected value at the first mismatch
- first_err_act  out  WIDTH  actual value at the first mismatch

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, FIFO empty, every output and counter 0, exp_ready=0.
- FSM state IDLE:
  - start=1 moves to RUN.
  - start=1 together with num_checks=0 moves directly to DONE.
- FSM state RUN:
  - busy=1; exp_ready = !full, derived from the registered FIFO occupancy.
  - A push occurs when exp_valid && exp_ready.
  - A compare occurs when act_valid && FIFO non-empty; it pops the head and compares head against act_data bitwise.
  - There is no same-cycle bypass: a value pushed in cycle N is comparable from cycle N+1.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - When full, exp_ready=0 even if a pop occurs that cycle; ready reopens the next cycle.
- Compare results:
  - Counters and capture registers update on the clock edge that ends the compare cycle. Latency is 1 cycle from act_valid to the visible count.
  - Match: correct_count+1.
  - Mismatch: error_count+1 and err_flag=1.
  - On the first mismatch only, record first_err_idx, first_err_exp and first_err_act.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- Underflow: act_valid with the FIFO empty sets underflow. No compare is made, nothing is counted, and the check index does not advance.
- End of run: the check index counts compares. When it reaches num_checks, the FSM goes to DONE on that same edge and the final count is visible together with done=1.
- FSM state DONE:
  - done=1, busy=0, exp_ready=0.
  - act_valid and exp_valid are ignored.
  - Results hold until the next start.
- Starting a new run: start in IDLE or DONE clears the counters, the sticky flags, the capture registers and the FIFO, then enters RUN. start during RUN is ignored.
- Reset mid-run: immediately returns to IDLE with all state cleared. Partial results are discarded.

Test Plan:
- Reset, then start with num_checks=3. Push 5, -3, 12 and return act 5, -3, 12 one cycle later each → correct_count=3, error_count=0, done=1 on the edge of the third compare, err_flag=0.
- num_checks=4. Expected 1, 2, 3, 4; actual 1, 7, 3, -8 → error_count=2, correct_count=2, first_err_idx=1, first_err_exp=2, first_err_act=7, err_flag=1.
- DEPTH=4: push 4 values with act_valid held 0 → exp_ready=0 after the 4th push. A 5th push together with the first act pop is refused; ready returns the next cycle.
- act_valid=1 before any push → underflow=1, both counts 0, busy stays 1. Then push 9, act 9 → correct_count=1.
- Reset asserted mid-run after 2 checks → all outputs 0, FSM IDLE. A subsequent start with num_checks=0 → done=1 the next cycle with counts 0.
- Drive 2^16+5 matches with num_checks=max (CNT_W=16) → correct_count saturates at 65535 and does not wrap.
